// File: rtl/rv32i_memory_arbiter_pkg.sv
// Shared types and defaults for the rv32i fetch/data memory arbiter.
package rv32i_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/rv32i_memory_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch is forced through
// after STARVE_LIMIT consecutive losses; the 1-clk read response is routed back.
module rv32i_memory_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_req,
  input  logic [ADDR_WIDTH-1:0]   instr_address,
  output logic                    instr_gnt,
  output logic                    instr_rvalid,
  output logic [DATA_WIDTH-1:0]   instr_rdata,
  input  logic                    data_req,
  input  logic                    data_write,
  input  logic [ADDR_WIDTH-1:0]   data_address,
  input  logic [DATA_WIDTH/8-1:0] data_byteenable,
  input  logic [DATA_WIDTH-1:0]   data_write_data,
  output logic                    data_gnt,
  output logic                    data_rvalid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  owner_e                  owner_q, owner_d;
  logic                    force_instr;

  assign force_instr = instr_req && (starve_q == LIMIT);
  assign data_gnt    = !reset && data_req && !force_instr;
  assign instr_gnt   = !reset && instr_req && !data_gnt;

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_write_data = '0;
    if (instr_gnt) begin
      mem_read       = 1'b1;
      mem_address    = instr_address;
      mem_byteenable = '1;
    end else if (data_gnt) begin
      mem_read       = !data_write;
      mem_write      = data_write;
      mem_address    = data_address;
      mem_byteenable = data_byteenable;
      mem_write_data = data_write_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (instr_gnt || !instr_req)
      starve_d = '0;
    else if (data_gnt && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;

    owner_d = OWNER_NONE;
    if (instr_gnt)
      owner_d = OWNER_INSTR;
    else if (data_gnt && !data_write)
      owner_d = OWNER_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      owner_q  <= OWNER_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Gating with reset drops a response whose grant preceded a reset.
  assign instr_rvalid = !reset && (owner_q == OWNER_INSTR);
  assign data_rvalid  = !reset && (owner_q == OWNER_DATA);
  assign instr_rdata  = mem_read_data;
  assign data_rdata   = mem_read_data;

endmodule

// File: tb/tb_rv32i_memory_arbiter.sv
// Directed bench for rv32i_memory_arbiter with a 1-clk-latency memory model.
module tb_rv32i_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_address;
  logic        instr_gnt, instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req, data_write;
  logic [31:0] data_address;
  logic [3:0]  data_byteenable;
  logic [31:0] data_write_data;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_write(data_write), .data_address(data_address),
    .data_byteenable(data_byteenable), .data_write_data(data_write_data),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Memory: words below 0x100 hold {16'hC0DE, word index}, the rest are zero.
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? {16'hC0DE, 16'(i)} : 32'h0;
    mem_read_data = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_read) mem_read_data <= mem[mem_address[9:2]];
    if (mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) mem[mem_address[9:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_req = 0; data_req = 0; data_write = 0;
    instr_address = 0; data_address = 0; data_byteenable = 0; data_write_data = 0;
  endtask

  logic [1:0] exp_pat [0:9];

  initial begin
    idle();
    // Reset held with both requesters active.
    reset = 1; instr_req = 1; data_req = 1; data_write = 1; data_byteenable = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("rst_outputs", {26'd0, instr_gnt, data_gnt, mem_read, mem_write, instr_rvalid, data_rvalid}, 32'h0);
      chk("rst_mem_addr", mem_address, 32'h0);
    end
    tick(); reset = 0; idle();
    @(negedge clk);
    chk("post_rst_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h0);

    // Fetch stream 0x0, 0x4, 0x8.
    tick(); instr_req = 1; instr_address = 32'h0;
    @(negedge clk);
    chk("f0_gnt", {29'd0, instr_gnt, mem_read, mem_write}, 32'h6);
    chk("f0_be", {28'd0, mem_byteenable}, 32'hF);
    tick(); instr_address = 32'h4;
    @(negedge clk);
    chk("f1_gnt", {31'd0, instr_gnt}, 32'h1);
    chk("f0_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h2);
    chk("f0_rdata", instr_rdata, 32'hC0DE0000);
    tick(); instr_address = 32'h8;
    @(negedge clk);
    chk("f2_addr", mem_address, 32'h8);
    chk("f1_rdata", instr_rdata, 32'hC0DE0001);
    tick(); idle();
    @(negedge clk);
    chk("f2_rvalid", {31'd0, instr_rvalid}, 32'h1);
    chk("f2_rdata", instr_rdata, 32'hC0DE0002);
    tick();
    @(negedge clk);
    chk("f_done_rvalid", {31'd0, instr_rvalid}, 32'h0);

    // Partial write then read-back.
    tick(); data_req = 1; data_write = 1; data_address = 32'h100;
    data_byteenable = 4'b0011; data_write_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_cmd", {28'd0, data_gnt, instr_gnt, mem_read, mem_write}, 32'h9);
    chk("wr_be", {28'd0, mem_byteenable}, 32'h3);
    chk("wr_data", mem_write_data, 32'hDEADBEEF);
    tick(); data_write = 0;
    @(negedge clk);
    chk("rd_cmd", {29'd0, data_gnt, mem_read, mem_write}, 32'h6);
    chk("wr_no_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("rd_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h1);
    chk("rd_rdata", data_rdata, 32'h0000BEEF);

    // Contention: D,D,D,D,I repeating with STARVE_LIMIT=4.
    exp_pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    tick(); instr_req = 1; instr_address = 32'h10; data_req = 1; data_address = 32'h100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("cont_gnt%0d", i), {30'd0, instr_gnt, data_gnt}, {30'd0, exp_pat[i]});
      if (i == 4) chk("cont_addr_I", mem_address, 32'h10);
      tick();
    end
    @(negedge clk);
    chk("cont_starve_after_I", {28'd0, dut.starve_q}, 32'h0);
    idle();

    // Mid-operation reset after a data read grant.
    tick(); instr_req = 1; data_req = 1; data_address = 32'h100;
    @(negedge clk);
    chk("mid_gnt", {30'd0, instr_gnt, data_gnt}, 32'h1);
    tick(); reset = 1;
    @(negedge clk);
    chk("mid_rst_rvalid", {28'd0, instr_gnt, data_gnt, instr_rvalid, data_rvalid}, 32'h0);
    tick(); reset = 0; idle();
    @(negedge clk);
    chk("mid_post_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h0);
    chk("mid_starve", {28'd0, dut.starve_q}, 32'h0);

    // Write granted while an earlier fetch response returns.
    tick(); instr_req = 1; instr_address = 32'h4;
    @(negedge clk);
    chk("ov_fetch_gnt", {31'd0, instr_gnt}, 32'h1);
    tick(); idle(); data_req = 1; data_write = 1; data_address = 32'h104;
    data_byteenable = 4'hF; data_write_data = 32'h12345678;
    @(negedge clk);
    chk("ov_wr_cmd", {29'd0, data_gnt, mem_write, mem_read}, 32'h6);
    chk("ov_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h2);
    chk("ov_rdata", instr_rdata, 32'hC0DE0001);
    tick(); idle();
    @(negedge clk);
    chk("ov_after_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_memory_arbiter.md
Name: rv32i_memory_arbiter

Overview:
Shares one single-port unified memory (1-clk read latency) between the rv32i_processor instruction-fetch port and its data port. Arbitrates per cycle with data-port priority and a starvation limiter for fetch. Routes the registered read response back to whichever requester issued the read. Sits between the processor's request ports and the memory model or SRAM.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses; byte enables are DATA_WIDTH/8 bits
STARVE_LIMIT, 4, max consecutive cycles fetch may lose to data before fetch is forced to win; legal range 1..15

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
instr_req  input  1  fetch read request
instr_address  input  ADDR_WIDTH  fetch address
instr_gnt  output  1  fetch request accepted this cycle
instr_rvalid  output  1  instr_rdata valid (1 cycle after an instr grant)
instr_rdata  output  DATA_WIDTH  fetch read data
data_req  input  1  data request (read or write)
data_write  input  1  1 = write, 0 = read
data_address  input  ADDR_WIDTH  data address
data_byteenable  input  DATA_WIDTH/8  write byte lanes
data_write_data  input  DATA_WIDTH  write data
data_gnt  output  1  data request accepted this cycle
data_rvalid  output  1  data_rdata valid (1 cycle after a data read grant)
data_rdata  output  DATA_WIDTH  data read data
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_address  output  ADDR_WIDTH  memory address
mem_byteenable  output  DATA_WIDTH/8  memory byte lanes
mem_write_data  output  DATA_WIDTH  memory write data
mem_read_data  input  DATA_WIDTH  memory read data, valid 1 cycle after mem_read

Behaviour:
- Grant is combinational in the request cycle; at most one of instr_gnt/data_gnt is high per cycle. The mem_* command is driven the same cycle from the granted requester.
- Priority: data wins when both request, unless starve_cnt == STARVE_LIMIT, in which case instr wins.
- starve_cnt (4-bit, registered): +1 when instr_req && data_gnt; cleared on instr_gnt or !instr_req; saturates at STARVE_LIMIT.
- Instr grant: mem_read=1, mem_address=instr_address, mem_byteenable=all ones, mem_write=0.
- Data grant: mem_write=data_write, mem_read=!data_write; address, byte enables and write data are passed through from the data port.
- No grant: mem_read=mem_write=0, other mem_* = 0.
- Response owner register resp_owner (enum NONE/INSTR/DATA) is set in the grant cycle: INSTR for an instr grant, DATA for a data read, NONE for a write or no grant.
- Next cycle: instr_rvalid=(resp_owner==INSTR) and data_rvalid=(resp_owner==DATA). Both rdata outputs equal mem_read_data, meaningful only while the matching rvalid is high.
- Back-to-back: a new grant may issue in the same cycle as the previous read's rvalid (full throughput, 1 access/cycle).
- Reset (while high): gnt=0, mem_read=mem_write=0, all mem_* = 0, requests ignored. Next edge: resp_owner=NONE, starve_cnt=0, so rvalid outputs are 0 in the first cycle after reset.
- Reset asserted the cycle after a read grant: that read's rvalid is suppressed and its response is dropped.
- A requester must hold its req and its fields stable until it receives gnt; the arbiter does not latch ungranted requests.

Decomposition:
- Package rv32i_mem_pkg holds the owner_e enum (OWNER_NONE, OWNER_INSTR, OWNER_DATA) and localparams for default widths and the starve counter width.
- No sub-module is needed; the starve counter and resp_owner register are inline.

Test Plan:
- Reset: hold reset for 10 cycles with both reqs high -> gnt, mem_read, mem_write and rvalid stay 0; rvalid is 0 in the first post-reset cycle.
- Fetch only: instr_req=1, addresses 0x0, 0x4, 0x8 on consecutive cycles -> instr_gnt=1 every cycle; instr_rvalid on cycles +1..+3 with rdata = mem[0x0], mem[0x4], mem[0x8].
- Data write then read: write 0xDEADBEEF with be=4'b0011 at 0x100, then read 0x100 -> mem_write for one cycle; data_rvalid one cycle after the read; data_rdata = 0x0000BEEF over a zeroed memory; instr_rvalid stays 0.
- Contention: both reqs held high continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; starve_cnt clears after each I.
- Mid-operation reset: data read granted, reset asserted the next cycle -> data_rvalid=0, starve_cnt=0, no stale response after reset deasserts.
- Write/response overlap: a data write granted in the same cycle an earlier fetch's response returns -> instr_rvalid=1 and data_rvalid=0 next cycle.
